// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared operation codes and step clamp for the up/down register
package reg_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_SCLR = 3'd1,
    OP_LOAD = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4
  } op_e;

  // A step larger than the count range is limited to the range itself.
  function automatic int unsigned clamp_step(input int unsigned raw, input int unsigned max_val);
    return (raw > max_val) ? max_val : raw;
  endfunction

endpackage

// File: rtl/reg_updown_nbit_if.sv
// rtl/reg_updown_nbit_if.sv - command and status bundle for the up/down register
interface reg_updown_nbit_if #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
) ();

  logic              sclr;
  logic              load;
  logic              incr;
  logic              decr;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  load_input;
  logic [WIDTH-1:0]  cmp_val;
  logic [WIDTH-1:0]  A;
  logic              wrap;
  logic              err;
  logic              match;

  modport master (
    output sclr, load, incr, decr, step, load_input, cmp_val,
    input  A, wrap, err, match
  );

  modport slave (
    input  sclr, load, incr, decr, step, load_input, cmp_val,
    output A, wrap, err, match
  );

endinterface

// File: rtl/reg_mod_addsub.sv
// rtl/reg_mod_addsub.sv - modular add/subtract over 0..MAX_VAL with wrap or clamp
module reg_mod_addsub #(
  parameter int          WIDTH    = 16,
  parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] s,
  input  logic             dec,
  output logic [WIDTH-1:0] nxt,
  output logic             bound
);

  // One extra bit so MAX_VAL + 1 and A + s never overflow.
  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD   = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, s};

  // Next value and boundary flag for the selected direction.
  always_comb begin
    nxt   = a;
    bound = 1'b0;
    if (!dec) begin
      if (sum > MAX_X) begin
        bound = 1'b1;
        nxt   = SATURATE ? MAX_W : WIDTH'(sum - MOD);
      end else begin
        nxt = WIDTH'(sum);
      end
    end else begin
      if (a >= s) begin
        nxt = a - s;
      end else begin
        bound = 1'b1;
        nxt   = SATURATE ? '0 : WIDTH'({1'b0, a} + MOD - {1'b0, s});
      end
    end
  end

endmodule

// File: rtl/reg_updown_nbit.sv
// rtl/reg_updown_nbit.sv - parametrised up/down counter register with wrap/saturate and status
module reg_updown_nbit #(
  parameter int          WIDTH    = 16,
  parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
  parameter int          STEP_W   = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic            clk,
  input  logic            clr,
  reg_updown_nbit_if.slave bus
);

  import reg_pkg::*;

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  op_e              op;
  logic [STEP_W-1:0] step_in;
  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] a_q, a_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] as_nxt;
  logic             as_bound;

  assign step_in = bus.step;
  assign s_eff   = WIDTH'(clamp_step(32'(step_in), MAX_VAL));

  // Command priority: sclr, then load, then a lone incr or decr.
  always_comb begin
    op = OP_HOLD;
    if (bus.sclr) begin
      op = OP_SCLR;
    end else if (bus.load) begin
      op = OP_LOAD;
    end else if (bus.incr ^ bus.decr) begin
      op = bus.incr ? OP_INC : OP_DEC;
    end
  end

  reg_mod_addsub #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_addsub (
    .a     (a_q),
    .s     (s_eff),
    .dec   (op == OP_DEC),
    .nxt   (as_nxt),
    .bound (as_bound)
  );

  // Next register value, pulse and sticky error; a zero step is a plain hold.
  always_comb begin
    a_d    = a_q;
    wrap_d = 1'b0;
    err_d  = err_q;
    case (op)
      OP_SCLR: begin
        a_d   = '0;
        err_d = 1'b0;
      end
      OP_LOAD: begin
        a_d   = (bus.load_input > MAX_W) ? MAX_W : bus.load_input;
        err_d = 1'b0;
      end
      OP_INC, OP_DEC: begin
        if (s_eff != '0) begin
          a_d    = as_nxt;
          wrap_d = as_bound;
          err_d  = err_q | as_bound;
        end
      end
      default: begin
      end
    endcase
  end

  // State flops; clr clears them immediately, independent of the clock.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.A     = a_q;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;
  assign bus.match = (a_q == bus.cmp_val);

endmodule

// File: tb/tb_reg_updown_nbit.sv
// tb/tb_reg_updown_nbit.sv - randomized and directed checks of reg_updown_nbit against a reference model
module tb_reg_updown_nbit;

  logic       clk = 1'b0;
  logic       clr;
  logic       sclr, load, incr, decr;
  logic [3:0] step;
  logic [7:0] load_input, cmp_val;

  always #5 clk = ~clk;

  reg_updown_nbit_if #(.WIDTH(8), .STEP_W(4)) ifs0 ();
  reg_updown_nbit_if #(.WIDTH(8), .STEP_W(4)) ifs1 ();
  reg_updown_nbit_if #(.WIDTH(8), .STEP_W(4)) ifs2 ();

  assign ifs0.sclr = sclr;  assign ifs1.sclr = sclr;  assign ifs2.sclr = sclr;
  assign ifs0.load = load;  assign ifs1.load = load;  assign ifs2.load = load;
  assign ifs0.incr = incr;  assign ifs1.incr = incr;  assign ifs2.incr = incr;
  assign ifs0.decr = decr;  assign ifs1.decr = decr;  assign ifs2.decr = decr;
  assign ifs0.step = step;  assign ifs1.step = step;  assign ifs2.step = step;
  assign ifs0.load_input = load_input;
  assign ifs1.load_input = load_input;
  assign ifs2.load_input = load_input;
  assign ifs0.cmp_val = cmp_val;
  assign ifs1.cmp_val = cmp_val;
  assign ifs2.cmp_val = cmp_val;

  reg_updown_nbit #(.WIDTH(8), .MAX_VAL(99), .STEP_W(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .clr(clr), .bus(ifs0));
  reg_updown_nbit #(.WIDTH(8), .MAX_VAL(99), .STEP_W(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .clr(clr), .bus(ifs1));
  reg_updown_nbit #(.WIDTH(8), .MAX_VAL(9), .STEP_W(4), .SATURATE(1'b0)) u_small (
    .clk(clk), .clr(clr), .bus(ifs2));

  int checks = 0;
  int errors = 0;

  int m_a[3];
  bit m_w[3];
  bit m_e[3];
  int maxv[3] = '{99, 99, 9};
  bit sat[3]  = '{1'b0, 1'b1, 1'b0};

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_a[i] = 0;
      m_w[i] = 1'b0;
      m_e[i] = 1'b0;
    end
  endfunction

  // Counting rules applied with plain integer arithmetic on the 0..max range.
  function automatic void model_edge();
    int s, t, li;
    if (clr) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      m_w[i] = 1'b0;
      if (sclr) begin
        m_a[i] = 0;
        m_e[i] = 1'b0;
      end else if (load) begin
        li     = int'(load_input);
        m_a[i] = (li > maxv[i]) ? maxv[i] : li;
        m_e[i] = 1'b0;
      end else if (incr != decr) begin
        s = (int'(step) > maxv[i]) ? maxv[i] : int'(step);
        if (s != 0) begin
          t = incr ? m_a[i] + s : m_a[i] - s;
          if (t > maxv[i]) begin
            m_w[i] = 1'b1;
            m_e[i] = 1'b1;
            m_a[i] = sat[i] ? maxv[i] : t - (maxv[i] + 1);
          end else if (t < 0) begin
            m_w[i] = 1'b1;
            m_e[i] = 1'b1;
            m_a[i] = sat[i] ? 0 : t + maxv[i] + 1;
          end else begin
            m_a[i] = t;
          end
        end
      end
    end
  endfunction

  task automatic check_inst(input int i, input int a, input int w, input int e, input int m);
    check($sformatf("i%0d_A", i), a, m_a[i]);
    check($sformatf("i%0d_wrap", i), w, int'(m_w[i]));
    check($sformatf("i%0d_err", i), e, int'(m_e[i]));
    check($sformatf("i%0d_match", i), m, (m_a[i] == int'(cmp_val)) ? 1 : 0);
  endtask

  task automatic check_model();
    check_inst(0, int'(ifs0.A), int'(ifs0.wrap), int'(ifs0.err), int'(ifs0.match));
    check_inst(1, int'(ifs1.A), int'(ifs1.wrap), int'(ifs1.err), int'(ifs1.match));
    check_inst(2, int'(ifs2.A), int'(ifs2.wrap), int'(ifs2.err), int'(ifs2.match));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle();
    sclr = 1'b0;
    load = 1'b0;
    incr = 1'b0;
    decr = 1'b0;
  endtask

  task automatic do_load(input int v);
    idle();
    load       = 1'b1;
    load_input = 8'(v);
    tick();
    load = 1'b0;
  endtask

  initial begin
    clr        = 1'b1;
    idle();
    step       = 4'd0;
    load_input = 8'd0;
    cmp_val    = 8'd200;
    model_reset();
    #12;
    check("rst_A", int'(ifs0.A), 0);
    check("rst_wrap", int'(ifs0.wrap), 0);
    check("rst_err", int'(ifs0.err), 0);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;

    // async clear from A=37 with err set
    do_load(96);
    incr = 1'b1; step = 4'd4;  tick();
    step = 4'd15; tick(); tick();
    step = 4'd7;  tick();
    idle();
    check("t1_pre_A", int'(ifs0.A), 37);
    check("t1_pre_err", int'(ifs0.err), 1);
    #2;
    clr = 1'b1;
    #1;
    check("t1_A", int'(ifs0.A), 0);
    check("t1_err", int'(ifs0.err), 0);
    check("t1_wrap", int'(ifs0.wrap), 0);
    model_reset();
    tick(); tick();
    clr = 1'b0;
    tick();
    check("t1_post_A", int'(ifs0.A), 0);

    // load and match
    cmp_val = 8'd42;
    do_load(42);
    check("t2_A", int'(ifs0.A), 42);
    check("t2_match", int'(ifs0.match), 1);
    do_load(150);
    check("t2_clamp", int'(ifs0.A), 99);
    check("t2_nomatch", int'(ifs0.match), 0);
    check("t2_clamp9", int'(ifs2.A), 9);

    // wrap up
    do_load(97);
    incr = 1'b1; step = 4'd5; tick();
    idle();
    check("t3_A", int'(ifs0.A), 2);
    check("t3_wrap", int'(ifs0.wrap), 1);
    check("t3_err", int'(ifs0.err), 1);
    check("t3_satA", int'(ifs1.A), 99);
    tick();
    check("t3_wrap_low", int'(ifs0.wrap), 0);
    check("t3_err_sticky", int'(ifs0.err), 1);

    // wrap down, then load clears err
    do_load(1);
    decr = 1'b1; step = 4'd3; tick();
    idle();
    check("t4_A", int'(ifs0.A), 98);
    check("t4_wrap", int'(ifs0.wrap), 1);
    check("t4_err", int'(ifs0.err), 1);
    check("t4_satA", int'(ifs1.A), 0);
    do_load(10);
    check("t4_err_clr", int'(ifs0.err), 0);

    // saturate instance
    do_load(98);
    incr = 1'b1; step = 4'd5; tick();
    check("t5_A", int'(ifs1.A), 99);
    check("t5_wrap", int'(ifs1.wrap), 1);
    tick();
    check("t5_rep_A", int'(ifs1.A), 99);
    check("t5_rep_wrap", int'(ifs1.wrap), 1);
    idle();
    decr = 1'b1; step = 4'd0; tick();
    check("t5_s0_A", int'(ifs1.A), 99);
    check("t5_s0_wrap", int'(ifs1.wrap), 0);
    do_load(2);
    decr = 1'b1; step = 4'd9; tick();
    idle();
    check("t5_lo_A", int'(ifs1.A), 0);
    check("t5_lo_err", int'(ifs1.err), 1);

    // priority
    do_load(50);
    incr = 1'b1; decr = 1'b1; step = 4'd3; tick();
    check("t6_both_A", int'(ifs0.A), 50);
    check("t6_both_wrap", int'(ifs0.wrap), 0);
    idle();
    load = 1'b1; incr = 1'b1; load_input = 8'd20; tick();
    check("t6_load_inc", int'(ifs0.A), 20);
    idle();
    sclr = 1'b1; load = 1'b1; load_input = 8'd33; tick();
    check("t6_sclr_load", int'(ifs0.A), 0);
    idle();
    incr = 1'b1; step = 4'd15; tick();
    idle();
    check("t6_clamp_A", int'(ifs2.A), 9);
    check("t6_clamp_wrap", int'(ifs2.wrap), 0);

    // randomized traffic, including occasional asynchronous clears
    for (int n = 0; n < 800; n++) begin
      clr        = ($urandom_range(0, 63) == 0);
      sclr       = ($urandom_range(0, 31) == 0);
      load       = ($urandom_range(0, 7) == 0);
      incr       = 1'($urandom_range(0, 1));
      decr       = 1'($urandom_range(0, 1));
      step       = 4'($urandom_range(0, 15));
      load_input = 8'($urandom_range(0, 255));
      cmp_val    = $urandom_range(0, 1) ? 8'(m_a[0]) : 8'($urandom_range(0, 99));
      tick();
    end
    clr = 1'b0;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
